gcd_req_driver: RTL and testbench
=================================

// Module: gcd_req_driver
// PURPOSE
//  Initiator for the gcd req/resp val/rdy interface: takes operand pairs from an upstream
//  command port, issues one request at a time to a gcd unit, collects each response into a
//  result FIFO, and counts completed transactions. Sits between a host/sequencer and gcd.
// PARAMETERS
//  OPW             16    operand width; req_msg = {a, b}, 2*OPW bits
//  RESW            16    gcd result width
//  FIFO_DEPTH      4     result FIFO entries, power of 2, >= 2
//  TIMEOUT_CYCLES  1024  watchdog limit, only used under GCD_DRV_TIMEOUT_EN
// PORTS
//  clk          in   1      clock, rising edge
//  reset_n      in   1      asynchronous active-low reset
//  cmd_val      in   1      upstream operand pair valid
//  cmd_rdy      out  1      driver can accept a pair
//  cmd_a        in   OPW    operand A
//  cmd_b        in   OPW    operand B
//  req_msg      out  2*OPW  request payload to gcd, {a, b}
//  req_val      out  1      request valid to gcd
//  req_rdy      in   1      gcd accepts request
//  resp_msg     in   RESW   gcd result
//  resp_val     in   1      gcd result valid
//  resp_rdy     out  1      driver accepts result
//  res_val      out  1      result FIFO non-empty
//  res_rdy      in   1      downstream pops result
//  res_data     out  RESW   FIFO head
//  txn_count    out  16     completed transactions, wraps at 2^16
//  busy         out  1      state != IDLE
//  timeout_err  out  1      sticky watchdog flag (present only with GCD_DRV_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (async, reset_n low): state IDLE, req_val=0, resp_rdy=0, req_msg=0, FIFO empty,
//    res_val=0, res_data=0, txn_count=0, busy=0, timeout_err=0. Reset mid-transaction
//    abandons it; no FIFO push; no count.
//  - FSM IDLE -> REQ -> WAIT -> IDLE.
//  - IDLE: cmd_rdy = (fifo_count < FIFO_DEPTH), combinational. cmd_rdy is 0 in REQ and WAIT.
//    On cmd_val & cmd_rdy, register {cmd_a, cmd_b} into req_msg and go to REQ.
//  - REQ: req_val=1. req_msg is held stable until req_rdy is sampled high. Then go to WAIT.
//    req_val drops the next cycle.
//  - WAIT: resp_rdy=1. A FIFO slot is guaranteed because the command was only accepted with
//    the FIFO not full and nothing else pushes. On resp_val, push resp_msg, increment
//    txn_count, go to IDLE.
//  - resp_val outside WAIT is ignored (resp_rdy=0). req_rdy outside REQ is ignored.
//  - Minimum latency with zero-wait gcd: cmd accept at cycle 0, req_val at 1, WAIT at 2,
//    push on the resp_val edge, res_val on the following cycle.
//  - FIFO is first-word fall-through: res_data = head, res_val = !empty, pop on
//    res_val & res_rdy.
//  - Push and pop in the same cycle: count unchanged, order preserved. Pop from empty is
//    a no-op.
//  - Operand values, including zero, are passed through uninterpreted.
//  - busy=1 in REQ and WAIT.
// CONFIGURATION
//  - GCD_DRV_TIMEOUT_EN defined: a counter runs in REQ and WAIT and clears on entry to IDLE.
//    On reaching TIMEOUT_CYCLES, timeout_err is set (sticky until reset), the FSM aborts to
//    IDLE, and req_val and resp_rdy drop the next cycle. No FIFO push, no txn_count
//    increment.
//  - GCD_DRV_TIMEOUT_EN undefined: the timeout_err port and counter are absent. The driver
//    waits indefinitely in REQ/WAIT.
// TESTING
//  1. Reset asserted mid-idle -> all outputs at reset values. After release, cmd_rdy=1,
//     busy=0.
//  2. a=48, b=18; gcd model holds req_rdy=1 and returns 6 after 5 cycles ->
//     req_msg=32'h0030_0012, res_data=6, res_val=1, txn_count=1.
//  3. req_rdy held low 3 cycles in REQ -> req_val=1 and req_msg unchanged across all 3,
//     exactly one request handshake.
//  4. res_rdy=0, issue 4 commands (results 1, 2, 3, 4) -> cmd_rdy=0 after 4th push.
//     5th command accepted only the cycle after one pop. Results are read out as 1, 2, 3, 4,
//     then the 5th.
//  5. reset_n pulsed low during WAIT, then resp_val=1 after release -> response ignored,
//     FIFO empty, txn_count=0.
//  6. GCD_DRV_TIMEOUT_EN, TIMEOUT_CYCLES=16, resp_val never asserted -> timeout_err=1 after
//     16 cycles in REQ/WAIT, state IDLE, res_val=0, txn_count=0.

Source files
------------

// File: rtl/gcd_req_driver_if.sv
// Handshake bundle between a gcd request driver and its surroundings: command in,
// gcd request/response, and the buffered result stream.
interface gcd_req_driver_if #(
   parameter int OPW  = 16,
   parameter int RESW = 16
);
   logic                cmd_val;
   logic                cmd_rdy;
   logic [OPW-1:0]      cmd_a;
   logic [OPW-1:0]      cmd_b;

   logic [2*OPW-1:0]    req_msg;
   logic                req_val;
   logic                req_rdy;

   logic [RESW-1:0]     resp_msg;
   logic                resp_val;
   logic                resp_rdy;

   logic                res_val;
   logic                res_rdy;
   logic [RESW-1:0]     res_data;

   // driver side
   modport master (
      input  cmd_val, cmd_a, cmd_b,
      output cmd_rdy,
      output req_msg, req_val,
      input  req_rdy,
      input  resp_msg, resp_val,
      output resp_rdy,
      output res_val, res_data,
      input  res_rdy
   );

   // host, gcd unit and result consumer side
   modport slave (
      output cmd_val, cmd_a, cmd_b,
      input  cmd_rdy,
      input  req_msg, req_val,
      output req_rdy,
      output resp_msg, resp_val,
      input  resp_rdy,
      input  res_val, res_data,
      output res_rdy
   );
endinterface

// File: rtl/gcd_req_driver.sv
// One-request-at-a-time initiator for a gcd unit with a first-word-fall-through result FIFO.
// Define GCD_DRV_TIMEOUT_EN to add the REQ/WAIT watchdog and the sticky timeout_err output.
//
// state  | meaning
// S_IDLE | accepting a command while the result FIFO has room
// S_REQ  | req_val high, req_msg held until req_rdy
// S_WAIT | resp_rdy high, waiting for the gcd result
module gcd_req_driver #(
   parameter int OPW            = 16,
   parameter int RESW           = 16,
   parameter int FIFO_DEPTH     = 4
`ifdef GCD_DRV_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic               clk,
   input  logic               reset_n,
   gcd_req_driver_if.master   bus,
   output logic [15:0]        txn_count,
   output logic               busy
`ifdef GCD_DRV_TIMEOUT_EN
   ,
   output logic               timeout_err
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t              state_q;
   logic [2*OPW-1:0]    req_msg_q;
   logic                req_val_q;
   logic                resp_rdy_q;
   logic                busy_q;
   logic [15:0]         txn_count_q;

   logic [RESW-1:0]     fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [CNT_W-1:0]    fifo_cnt_q;
   logic [CNT_W-1:0]    fifo_cnt_d;

   logic                cmd_rdy;
   logic                cmd_fire;
   logic                tmo_hit;
   logic                push;
   logic                pop;

   assign cmd_rdy  = (state_q == S_IDLE) && (fifo_cnt_q < CNT_W'(FIFO_DEPTH));
   assign cmd_fire = cmd_rdy && bus.cmd_val;
   // a watchdog expiry in the same cycle as a response wins: the response is dropped
   assign push     = (state_q == S_WAIT) && bus.resp_val && !tmo_hit;
   assign pop      = (fifo_cnt_q != '0) && bus.res_rdy;

`ifdef GCD_DRV_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0]    tmo_cnt_q;
   logic                timeout_err_q;

   // down-counter loaded on command accept; reaching zero while busy marks the last allowed cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (cmd_fire) begin
            tmo_cnt_q <= TMO_W'(TIMEOUT_CYCLES - 1);
         end else if (state_q == S_IDLE) begin
            tmo_cnt_q <= '0;
         end else if (tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
         end
         if (tmo_hit) begin
            timeout_err_q <= 1'b1;
         end
      end
   end

   assign tmo_hit     = (state_q != S_IDLE) && (tmo_cnt_q == '0);
   assign timeout_err = timeout_err_q;
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         req_msg_q   <= '0;
         req_val_q   <= 1'b0;
         resp_rdy_q  <= 1'b0;
         busy_q      <= 1'b0;
         txn_count_q <= '0;
      end else if (tmo_hit) begin
         state_q    <= S_IDLE;
         req_val_q  <= 1'b0;
         resp_rdy_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_fire) begin
                  req_msg_q <= {bus.cmd_a, bus.cmd_b};
                  req_val_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.req_rdy) begin
                  req_val_q  <= 1'b0;
                  resp_rdy_q <= 1'b1;
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.resp_val) begin
                  resp_rdy_q  <= 1'b0;
                  busy_q      <= 1'b0;
                  txn_count_q <= txn_count_q + 16'd1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               req_val_q  <= 1'b0;
               resp_rdy_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // storage is cleared on reset so res_data reads zero while empty after reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= bus.resp_msg;
            wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   assign bus.cmd_rdy  = cmd_rdy;
   assign bus.req_msg  = req_msg_q;
   assign bus.req_val  = req_val_q;
   assign bus.resp_rdy = resp_rdy_q;
   assign bus.res_val  = (fifo_cnt_q != '0);
   assign bus.res_data = fifo_mem_q[rd_ptr_q];
   assign txn_count    = txn_count_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_gcd_req_driver.sv
// Bench for gcd_req_driver: acts as host, gcd unit and result consumer, with a queue model
// of the result stream. Define GCD_DRV_TIMEOUT_EN to build the watchdog variant.
module tb_gcd_req_driver;
   localparam int OPW   = 16;
   localparam int RESW  = 16;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [15:0]   txn_count;
   logic          busy;
`ifdef GCD_DRV_TIMEOUT_EN
   logic          timeout_err;
`endif

   int            checks = 0;
   int            errors = 0;
   logic [RESW-1:0] exp_q[$];
   int            exp_txn = 0;

   gcd_req_driver_if #(.OPW(OPW), .RESW(RESW)) bus();

   gcd_req_driver #(
      .OPW(OPW), .RESW(RESW), .FIFO_DEPTH(DEPTH)
`ifdef GCD_DRV_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TMO)
`endif
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .txn_count(txn_count), .busy(busy)
`ifdef GCD_DRV_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [RESW-1:0] gcd_f(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
      logic [OPW-1:0] x = a;
      logic [OPW-1:0] y = b;
      logic [OPW-1:0] t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return RESW'(x);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // waits for cmd_rdy, presents one command for exactly the accepting cycle
   task automatic issue_cmd(input logic [OPW-1:0] a, input logic [OPW-1:0] b, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.cmd_rdy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) return;
      bus.cmd_a   = a;
      bus.cmd_b   = b;
      bus.cmd_val = 1'b1;
      tick();
      bus.cmd_val = 1'b0;
   endtask

   // gcd unit behaviour: stall req_rdy, then answer after a delay, optionally popping alongside
   task automatic serve(input int req_wait, input int resp_delay, input bit pop_same,
                        output bit ok, output logic [2*OPW-1:0] seen_msg,
                        output bit popped, output logic [RESW-1:0] pop_data);
      ok = 1'b0;
      popped = 1'b0;
      pop_data = '0;
      seen_msg = '0;
      for (int i = 0; i < 50; i++) begin
         if (bus.req_val) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) return;
      seen_msg = bus.req_msg;
      repeat (req_wait) tick();
      bus.req_rdy = 1'b1;
      tick();
      bus.req_rdy = 1'b0;
      repeat (resp_delay) tick();
      bus.resp_msg = gcd_f(seen_msg[2*OPW-1:OPW], seen_msg[OPW-1:0]);
      bus.resp_val = 1'b1;
      if (pop_same && bus.res_val) begin
         bus.res_rdy = 1'b1;
         popped = 1'b1;
         pop_data = bus.res_data;
      end
      tick();
      bus.resp_val = 1'b0;
      bus.res_rdy  = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      bus.res_rdy = 1'b1;
      tick();
      bus.res_rdy = 1'b0;
      checks++;
      if (bus.res_val !== 1'b0 || bus.cmd_rdy !== 1'b1) begin
         errors++;
         $display("FAIL pop_empty: res_val=%b cmd_rdy=%b, required 0 1", bus.res_val, bus.cmd_rdy);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.req_val, bus.resp_rdy, bus.res_val, busy} !== 4'b0 || bus.req_msg !== '0 ||
          bus.res_data !== '0 || txn_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_values: req_val=%b resp_rdy=%b res_val=%b busy=%b req_msg=%h res_data=%h txn=%0d, required all zero",
                  bus.req_val, bus.resp_rdy, bus.res_val, busy, bus.req_msg, bus.res_data, txn_count);
      end
`ifdef GCD_DRV_TIMEOUT_EN
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_timeout_err: got %b required 0", timeout_err);
      end
`endif
      tick();
      reset_n = 1'b1;
      tick();
      checks++;
      if (bus.cmd_rdy !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL after_reset: cmd_rdy=%b busy=%b, required 1 0", bus.cmd_rdy, busy);
      end
   endtask

   task automatic test_basic();
      bit ok;
      bus.req_rdy = 1'b1;
      issue_cmd(16'd48, 16'd18, ok);
      checks++;
      if (!ok || bus.req_val !== 1'b1 || bus.req_msg !== 32'h0030_0012) begin
         errors++;
         $display("FAIL basic_req: ok=%b req_val=%b req_msg=%h, required 1 1 00300012", ok, bus.req_val, bus.req_msg);
      end
      tick();
      bus.req_rdy = 1'b0;
      checks++;
      if (bus.resp_rdy !== 1'b1 || bus.req_val !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_wait: resp_rdy=%b req_val=%b busy=%b, required 1 0 1", bus.resp_rdy, bus.req_val, busy);
      end
      repeat (3) tick();
      bus.resp_msg = gcd_f(16'd48, 16'd18);
      bus.resp_val = 1'b1;
      tick();
      bus.resp_val = 1'b0;
      exp_txn++;
      checks++;
      if (bus.res_val !== 1'b1 || bus.res_data !== 16'd6 || txn_count !== 16'(exp_txn) || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: res_val=%b res_data=%0d txn=%0d busy=%b, required 1 6 %0d 0",
                  bus.res_val, bus.res_data, txn_count, busy, exp_txn);
      end
      bus.res_rdy = 1'b1;
      tick();
      bus.res_rdy = 1'b0;
      checks++;
      if (bus.res_val !== 1'b0) begin
         errors++;
         $display("FAIL basic_pop: res_val=%b required 0", bus.res_val);
      end
   endtask

   task automatic test_req_stall();
      bit ok, stable;
      int hs;
      logic [OPW-1:0] a, b;
      logic [2*OPW-1:0] msg0;
      a = OPW'($urandom);
      b = OPW'($urandom);
      bus.req_rdy = 1'b0;
      issue_cmd(a, b, ok);
      msg0 = bus.req_msg;
      checks++;
      if (!ok || msg0 !== {a, b}) begin
         errors++;
         $display("FAIL stall_msg: ok=%b req_msg=%h required %h", ok, msg0, {a, b});
      end
      stable = 1'b1;
      hs = 0;
      for (int i = 0; i < 3; i++) begin
         if (bus.req_val !== 1'b1 || bus.req_msg !== msg0) stable = 1'b0;
         if (bus.req_val && bus.req_rdy) hs++;
         tick();
      end
      bus.req_rdy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (bus.req_val && bus.req_rdy) hs++;
         tick();
      end
      bus.req_rdy = 1'b0;
      checks++;
      if (!stable || hs != 1 || bus.resp_rdy !== 1'b1) begin
         errors++;
         $display("FAIL stall_handshake: stable=%b handshakes=%0d resp_rdy=%b, required 1 1 1", stable, hs, bus.resp_rdy);
      end
      bus.resp_msg = gcd_f(a, b);
      bus.resp_val = 1'b1;
      tick();
      bus.resp_val = 1'b0;
      exp_q.push_back(gcd_f(a, b));
      exp_txn++;
      while (exp_q.size() > 0) begin
         checks++;
         if (bus.res_val !== 1'b1 || bus.res_data !== exp_q[0]) begin
            errors++;
            $display("FAIL stall_result: res_val=%b res_data=%h required 1 %h", bus.res_val, bus.res_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         bus.res_rdy = 1'b1;
         tick();
         bus.res_rdy = 1'b0;
      end
   endtask

   task automatic test_fifo_full();
      bit ok, popped, never;
      logic [2*OPW-1:0] m;
      logic [RESW-1:0] pd;
      logic [OPW-1:0] av [4] = '{16'd7, 16'd4, 16'd9, 16'd8};
      logic [OPW-1:0] bv [4] = '{16'd5, 16'd6, 16'd6, 16'd12};
      bus.res_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue_cmd(av[i], bv[i], ok);
         serve(0, i, 1'b0, ok, m, popped, pd);
         exp_q.push_back(gcd_f(av[i], bv[i]));
         exp_txn++;
      end
      checks++;
      if (bus.cmd_rdy !== 1'b0 || bus.res_val !== 1'b1) begin
         errors++;
         $display("FAIL full_cmd_rdy: cmd_rdy=%b res_val=%b, required 0 1", bus.cmd_rdy, bus.res_val);
      end
      bus.cmd_a = 16'd10;
      bus.cmd_b = 16'd15;
      bus.cmd_val = 1'b1;
      never = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (busy !== 1'b0 || bus.cmd_rdy !== 1'b0) never = 1'b0;
      end
      checks++;
      if (!never) begin
         errors++;
         $display("FAIL full_blocked: command accepted while FIFO full (busy=%b), required busy 0", busy);
      end
      checks++;
      if (bus.res_data !== exp_q[0] || exp_q[0] !== 16'd1) begin
         errors++;
         $display("FAIL full_head: res_data=%0d required %0d", bus.res_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      bus.res_rdy = 1'b1;
      tick();
      bus.res_rdy = 1'b0;
      checks++;
      if (bus.cmd_rdy !== 1'b1) begin
         errors++;
         $display("FAIL full_after_pop: cmd_rdy=%b required 1", bus.cmd_rdy);
      end
      tick();
      bus.cmd_val = 1'b0;
      checks++;
      if (busy !== 1'b1 || bus.req_msg !== {16'd10, 16'd15}) begin
         errors++;
         $display("FAIL full_fifth_accept: busy=%b req_msg=%h required 1 000a000f", busy, bus.req_msg);
      end
      serve(1, 2, 1'b0, ok, m, popped, pd);
      exp_q.push_back(gcd_f(16'd10, 16'd15));
      exp_txn++;
      while (exp_q.size() > 0) begin
         checks++;
         if (bus.res_val !== 1'b1 || bus.res_data !== exp_q[0]) begin
            errors++;
            $display("FAIL full_order: res_val=%b res_data=%0d required 1 %0d", bus.res_val, bus.res_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         bus.res_rdy = 1'b1;
         tick();
         bus.res_rdy = 1'b0;
      end
      checks++;
      if (txn_count !== 16'(exp_txn) || bus.res_val !== 1'b0) begin
         errors++;
         $display("FAIL full_txn: txn=%0d res_val=%b required %0d 0", txn_count, bus.res_val, exp_txn);
      end
   endtask

   task automatic test_random();
      bit ok, popped;
      logic [2*OPW-1:0] m;
      logic [RESW-1:0] pd;
      logic [OPW-1:0] a, b;
      int ndrain;
      for (int it = 0; it < 30; it++) begin
         a = ($urandom_range(0, 7) == 0) ? '0 : OPW'($urandom_range(0, 2000));
         b = ($urandom_range(0, 7) == 0) ? '0 : OPW'($urandom_range(0, 2000));
         issue_cmd(a, b, ok);
         serve($urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)), ok, m, popped, pd);
         checks++;
         if (!ok || m !== {a, b}) begin
            errors++;
            $display("FAIL rand_req: ok=%b req_msg=%h required %h", ok, m, {a, b});
         end
         if (popped) begin
            checks++;
            if (exp_q.size() == 0 || pd !== exp_q[0]) begin
               errors++;
               $display("FAIL rand_pop_push: popped=%h required %h", pd, (exp_q.size() > 0) ? exp_q[0] : '0);
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         exp_q.push_back(gcd_f(a, b));
         exp_txn++;
         ndrain = (exp_q.size() == DEPTH) ? $urandom_range(1, DEPTH) : $urandom_range(0, 1);
         for (int k = 0; k < ndrain && exp_q.size() > 0; k++) begin
            checks++;
            if (bus.res_val !== 1'b1 || bus.res_data !== exp_q[0]) begin
               errors++;
               $display("FAIL rand_result: res_val=%b res_data=%h required 1 %h", bus.res_val, bus.res_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            bus.res_rdy = 1'b1;
            tick();
            bus.res_rdy = 1'b0;
         end
      end
      while (exp_q.size() > 0) begin
         checks++;
         if (bus.res_val !== 1'b1 || bus.res_data !== exp_q[0]) begin
            errors++;
            $display("FAIL rand_drain: res_val=%b res_data=%h required 1 %h", bus.res_val, bus.res_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         bus.res_rdy = 1'b1;
         tick();
         bus.res_rdy = 1'b0;
      end
      checks++;
      if (txn_count !== 16'(exp_txn) || bus.res_val !== 1'b0) begin
         errors++;
         $display("FAIL rand_txn: txn=%0d res_val=%b required %0d 0", txn_count, bus.res_val, exp_txn);
      end
   endtask

   task automatic test_reset_wait();
      bit ok, popped;
      logic [2*OPW-1:0] m;
      logic [RESW-1:0] pd;
      bus.res_rdy = 1'b0;
      issue_cmd(16'd21, 16'd14, ok);
      serve(0, 1, 1'b0, ok, m, popped, pd);
      bus.req_rdy = 1'b1;
      issue_cmd(16'd30, 16'd12, ok);
      tick();
      bus.req_rdy = 1'b0;
      checks++;
      if (bus.resp_rdy !== 1'b1 || bus.res_val !== 1'b1) begin
         errors++;
         $display("FAIL rstwait_setup: resp_rdy=%b res_val=%b required 1 1", bus.resp_rdy, bus.res_val);
      end
      #2 reset_n = 1'b0;
      #2;
      exp_txn = 0;
      exp_q.delete();
      checks++;
      if (busy !== 1'b0 || bus.resp_rdy !== 1'b0 || bus.res_val !== 1'b0 || txn_count !== 16'd0) begin
         errors++;
         $display("FAIL rstwait_async: busy=%b resp_rdy=%b res_val=%b txn=%0d required 0 0 0 0",
                  busy, bus.resp_rdy, bus.res_val, txn_count);
      end
      tick();
      reset_n = 1'b1;
      bus.resp_msg = 16'h0055;
      bus.resp_val = 1'b1;
      repeat (2) tick();
      bus.resp_val = 1'b0;
      checks++;
      if (bus.res_val !== 1'b0 || txn_count !== 16'd0 || busy !== 1'b0 || bus.cmd_rdy !== 1'b1) begin
         errors++;
         $display("FAIL rstwait_ignored: res_val=%b txn=%0d busy=%b cmd_rdy=%b required 0 0 0 1",
                  bus.res_val, txn_count, busy, bus.cmd_rdy);
      end
   endtask

`ifdef GCD_DRV_TIMEOUT_EN
   task automatic test_timeout();
      bit ok, popped;
      logic [2*OPW-1:0] m;
      logic [RESW-1:0] pd;
      int n;
      for (int phase = 0; phase < 2; phase++) begin
         bus.req_rdy = (phase == 1);
         issue_cmd(16'd3, 16'd9, ok);
         n = 1;
         for (int i = 0; i < 100; i++) begin
            tick();
            bus.req_rdy = 1'b0;
            if (busy) n++;
            else break;
         end
         checks++;
         if (n != TMO || timeout_err !== 1'b1 || bus.req_val !== 1'b0 || bus.resp_rdy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_phase%0d: busy_cycles=%0d err=%b req_val=%b resp_rdy=%b required %0d 1 0 0",
                     phase, n, timeout_err, bus.req_val, bus.resp_rdy, TMO);
         end
         bus.resp_msg = 16'd3;
         bus.resp_val = 1'b1;
         tick();
         bus.resp_val = 1'b0;
         checks++;
         if (bus.res_val !== 1'b0 || txn_count !== 16'd0) begin
            errors++;
            $display("FAIL timeout_nopush%0d: res_val=%b txn=%0d required 0 0", phase, bus.res_val, txn_count);
         end
      end
      issue_cmd(16'd35, 16'd49, ok);
      serve(0, 1, 1'b0, ok, m, popped, pd);
      checks++;
      if (bus.res_data !== gcd_f(16'd35, 16'd49) || txn_count !== 16'd1 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: res_data=%0d txn=%0d err=%b required %0d 1 1",
                  bus.res_data, txn_count, timeout_err, gcd_f(16'd35, 16'd49));
      end
   endtask
`else
   task automatic test_no_timeout();
      bit ok;
      bus.req_rdy = 1'b0;
      issue_cmd(16'd12, 16'd8, ok);
      repeat (1100) tick();
      checks++;
      if (busy !== 1'b1 || bus.req_val !== 1'b1) begin
         errors++;
         $display("FAIL no_timeout: busy=%b req_val=%b required 1 1", busy, bus.req_val);
      end
      bus.req_rdy = 1'b1;
      tick();
      bus.req_rdy = 1'b0;
      bus.resp_msg = gcd_f(16'd12, 16'd8);
      bus.resp_val = 1'b1;
      tick();
      bus.resp_val = 1'b0;
      checks++;
      if (bus.res_data !== 16'd4 || txn_count !== 16'd1) begin
         errors++;
         $display("FAIL no_timeout_done: res_data=%0d txn=%0d required 4 1", bus.res_data, txn_count);
      end
   endtask
`endif

   initial begin
      bus.cmd_val  = 1'b0;
      bus.cmd_a    = '0;
      bus.cmd_b    = '0;
      bus.req_rdy  = 1'b0;
      bus.resp_msg = '0;
      bus.resp_val = 1'b0;
      bus.res_rdy  = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_req_stall();
      test_fifo_full();
      test_random();
      test_reset_wait();
`ifdef GCD_DRV_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
